// File: rtl/fetch_queue.sv
// Instruction buffer between 2-wide fetch and decode: packs valid fetch slots into a circular buffer.
// Optional FETCH_QUEUE_PERF_EN adds saturating stall/empty cycle counters.
module fetch_queue #(
  parameter int FETCH_W = 2,
  parameter int DEC_W   = 2,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FETCH_W-1:0]            if_valid,
  input  logic [FETCH_W*PC_W-1:0]       if_pc,
  input  logic [FETCH_W*INSTR_W-1:0]    if_instr,
  input  logic                          flush,
  output logic                          ibuf_stall,
  input  logic                          id_ready,
  output logic [DEC_W-1:0]              id_valid,
  output logic [DEC_W*PC_W-1:0]         id_pc,
  output logic [DEC_W*INSTR_W-1:0]      id_instr,
  output logic [$clog2(DEPTH+1)-1:0]    count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cycles,
  output logic [31:0]                   perf_empty_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PC_W-1:0]    r_pc    [DEPTH];
  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic [CNT_W-1:0]   w_enq_cnt;
  logic [CNT_W-1:0]   w_enq_acc;
  logic [CNT_W-1:0]   w_deq;
  logic [CNT_W-1:0]   w_free;
  logic               w_fits;
  logic [PTR_W-1:0]   w_wr_idx [FETCH_W];
  logic [PTR_W-1:0]   w_rd_idx [DEC_W];

  // Slot i lands at tail + popcount of the valid slots below it.
  always_comb begin
    w_enq_cnt = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      w_wr_idx[i] = r_tail + PTR_W'(w_enq_cnt);
      if (if_valid[i]) w_enq_cnt = w_enq_cnt + CNT_W'(1);
    end
  end

  assign w_free     = CNT_W'(DEPTH) - r_count;
  assign w_fits     = (w_free >= w_enq_cnt);
  assign w_enq_acc  = w_fits ? w_enq_cnt : '0;
  assign w_deq      = !id_ready ? '0 :
                      (r_count < CNT_W'(DEC_W)) ? r_count : CNT_W'(DEC_W);
  assign ibuf_stall = (w_free < CNT_W'(2*FETCH_W));
  assign count      = r_count;

  always_comb begin
    id_valid = '0;
    id_pc    = '0;
    id_instr = '0;
    for (int unsigned i = 0; i < DEC_W; i++) begin
      w_rd_idx[i] = r_head + PTR_W'(i);
      id_valid[i] = (r_count > CNT_W'(i));
      id_pc[i*PC_W +: PC_W]          = r_pc[w_rd_idx[i]];
      id_instr[i*INSTR_W +: INSTR_W] = r_instr[w_rd_idx[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_fits) begin
        for (int unsigned i = 0; i < FETCH_W; i++) begin
          if (if_valid[i]) begin
            r_pc[w_wr_idx[i]]    <= if_pc[i*PC_W +: PC_W];
            r_instr[w_wr_idx[i]] <= if_instr[i*INSTR_W +: INSTR_W];
          end
        end
      end
      r_tail  <= r_tail + PTR_W'(w_enq_acc);
      r_head  <= r_head + PTR_W'(w_deq);
      r_count <= r_count + w_enq_acc - w_deq;
    end
  end

  // Free space is judged before dequeue, so a group that does not fit is dropped whole.
  always_ff @(posedge clk) begin
    a_no_overflow: assert (reset || flush || w_fits);
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_empty <= '0;
    end else begin
      if (ibuf_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if ((r_count == '0) && (r_perf_empty != '1)) r_perf_empty <= r_perf_empty + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_empty_cycles = r_perf_empty;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH 8, 2-wide in/out).
// Build with FETCH_QUEUE_PERF_EN defined to also exercise the perf counters.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  if_valid;
  logic [63:0] if_pc;
  logic [63:0] if_instr;
  logic        flush;
  logic        ibuf_stall;
  logic        id_ready;
  logic [1:0]  id_valid;
  logic [63:0] id_pc;
  logic [63:0] id_instr;
  logic [3:0]  count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_empty_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_queue #(.FETCH_W(2), .DEC_W(2), .PC_W(32), .INSTR_W(32), .DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .flush      (flush),
    .ibuf_stall (ibuf_stall),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .count      (count)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                       input logic [31:0] p1, input logic [31:0] i1);
    if_valid = v;
    if_pc    = {p1, p0};
    if_instr = {i1, i0};
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; id_ready = 1'b1;
    drive(2'b11, 32'hAA, 32'hBB, 32'hCC, 32'hDD);
    tick(); tick();
    reset = 1'b0;
    drive(2'b00, 0, 0, 0, 0);
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_vec++; if (id_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid got=%b exp=00", id_valid); end
    n_vec++; if (id_pc !== 64'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
    n_vec++; if (id_instr !== 64'h0) begin n_err++; $display("FAIL reset_instr got=%h exp=0", id_instr); end
    n_vec++; if (ibuf_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", ibuf_stall); end
  endtask

  task automatic test_pairs();
    id_ready = 1'b1;
    drive(2'b11, 32'h00, 32'h11111111, 32'h04, 32'h22222222);
    tick();
    n_vec++; if (id_valid !== 2'b11) begin n_err++; $display("FAIL pairA_valid got=%b exp=11", id_valid); end
    n_vec++; if (id_pc !== {32'h04, 32'h00}) begin n_err++; $display("FAIL pairA_pc got=%h exp=%h", id_pc, {32'h04, 32'h00}); end
    n_vec++; if (id_instr !== {32'h22222222, 32'h11111111}) begin n_err++; $display("FAIL pairA_instr got=%h", id_instr); end
    drive(2'b11, 32'h08, 32'h33333333, 32'h0C, 32'h44444444);
    tick();
    n_vec++; if (count !== 4'd2) begin n_err++; $display("FAIL pairB_count got=%0d exp=2", count); end
    n_vec++; if (id_pc !== {32'h0C, 32'h08}) begin n_err++; $display("FAIL pairB_pc got=%h exp=%h", id_pc, {32'h0C, 32'h08}); end
    n_vec++; if (id_instr !== {32'h44444444, 32'h33333333}) begin n_err++; $display("FAIL pairB_instr got=%h", id_instr); end
    drive(2'b00, 0, 0, 0, 0);
    tick();
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL pairs_drain got=%0d exp=0", count); end
    n_vec++; if (id_valid !== 2'b00) begin n_err++; $display("FAIL pairs_empty_valid got=%b exp=00", id_valid); end
  endtask

  task automatic test_pack();
    id_ready = 1'b0;
    drive(2'b10, 32'hDEAD, 32'hDEADBEEF, 32'h14, 32'h66666666);
    tick();
    n_vec++; if (id_valid !== 2'b01) begin n_err++; $display("FAIL pack_valid got=%b exp=01", id_valid); end
    n_vec++; if (id_pc[31:0] !== 32'h14) begin n_err++; $display("FAIL pack_pc got=%h exp=14", id_pc[31:0]); end
    n_vec++; if (id_instr[31:0] !== 32'h66666666) begin n_err++; $display("FAIL pack_instr got=%h exp=66666666", id_instr[31:0]); end
    n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL pack_count got=%0d exp=1", count); end
    id_ready = 1'b1;
    drive(2'b00, 0, 0, 0, 0);
    tick();
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL pack_drain got=%0d exp=0", count); end
  endtask

  task automatic test_fill_stall();
    id_ready = 1'b0;
    drive(2'b11, 32'h100, 32'hA100, 32'h104, 32'hA104);
    tick();
    drive(2'b11, 32'h108, 32'hA108, 32'h10C, 32'hA10C);
    tick();
    n_vec++; if (ibuf_stall !== 1'b0) begin n_err++; $display("FAIL stall_at4 got=%b exp=0", ibuf_stall); end
    drive(2'b01, 32'h110, 32'hA110, 32'h0, 32'h0);
    tick();
    n_vec++; if (count !== 4'd5) begin n_err++; $display("FAIL fill_count5 got=%0d exp=5", count); end
    n_vec++; if (ibuf_stall !== 1'b1) begin n_err++; $display("FAIL stall_at5 got=%b exp=1", ibuf_stall); end
    drive(2'b11, 32'h114, 32'hA114, 32'h118, 32'hA118);
    tick();
    drive(2'b01, 32'h11C, 32'hA11C, 32'h0, 32'h0);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL full_count got=%0d exp=8", count); end
    n_vec++; if (ibuf_stall !== 1'b1) begin n_err++; $display("FAIL full_stall got=%b exp=1", ibuf_stall); end
    tick();
    n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL full_hold got=%0d exp=8", count); end
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (id_pc !== {32'h104 + 32'(8*k), 32'h100 + 32'(8*k)}) begin
        n_err++; $display("FAIL fill_drain%0d got=%h exp=%h", k, id_pc, {32'h104 + 32'(8*k), 32'h100 + 32'(8*k)});
      end
      tick();
    end
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL fill_drained got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    logic [31:0] nxt_pc;
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 32'h200 + 32'(8*k), 32'hB0, 32'h204 + 32'(8*k), 32'hB4);
      tick();
    end
    n_vec++; if (count !== 4'd6) begin n_err++; $display("FAIL wrap_fill got=%0d exp=6", count); end
    exp_pc = 32'h200;
    nxt_pc = 32'h218;
    id_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (id_pc !== {exp_pc + 32'h4, exp_pc} || count !== 4'd6) begin
        n_err++; $display("FAIL wrap_steady%0d got=%h/%0d exp=%h/6", k, id_pc, count, {exp_pc + 32'h4, exp_pc});
      end
      drive(2'b11, nxt_pc, 32'hB0, nxt_pc + 32'h4, 32'hB4);
      nxt_pc = nxt_pc + 32'h8;
      exp_pc = exp_pc + 32'h8;
      tick();
    end
    drive(2'b00, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (id_pc !== {exp_pc + 32'h4, exp_pc}) begin
        n_err++; $display("FAIL wrap_drain%0d got=%h exp=%h", k, id_pc, {exp_pc + 32'h4, exp_pc});
      end
      exp_pc = exp_pc + 32'h8;
      tick();
    end
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL wrap_empty got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    id_ready = 1'b0;
    drive(2'b11, 32'h280, 32'h1, 32'h284, 32'h2);
    tick();
    drive(2'b11, 32'h288, 32'h3, 32'h28C, 32'h4);
    tick();
    drive(2'b01, 32'h290, 32'h5, 32'h0, 32'h0);
    tick();
    n_vec++; if (count !== 4'd5) begin n_err++; $display("FAIL flush_pre got=%0d exp=5", count); end
    flush = 1'b1;
    id_ready = 1'b1;
    drive(2'b11, 32'h300, 32'h6, 32'h304, 32'h7);
    tick();
    flush = 1'b0;
    id_ready = 1'b0;
    drive(2'b00, 0, 0, 0, 0);
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_count got=%0d exp=0", count); end
    n_vec++; if (id_valid !== 2'b00) begin n_err++; $display("FAIL flush_valid got=%b exp=00", id_valid); end
    n_vec++; if (ibuf_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got=%b exp=0", ibuf_stall); end
    drive(2'b11, 32'h08, 32'h77777777, 32'h0C, 32'h88888888);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    n_vec++; if (id_valid !== 2'b11) begin n_err++; $display("FAIL postflush_valid got=%b exp=11", id_valid); end
    n_vec++; if (id_pc !== {32'h0C, 32'h08}) begin n_err++; $display("FAIL postflush_pc got=%h exp=%h", id_pc, {32'h0C, 32'h08}); end
    n_vec++; if (id_instr !== {32'h88888888, 32'h77777777}) begin n_err++; $display("FAIL postflush_instr got=%h", id_instr); end
  endtask

  task automatic test_mid_reset();
    drive(2'b11, 32'h400, 32'h9, 32'h404, 32'hA);
    tick();
    n_vec++; if (count !== 4'd4) begin n_err++; $display("FAIL midrst_pre got=%0d exp=4", count); end
    reset = 1'b1;
    drive(2'b11, 32'h500, 32'hB, 32'h504, 32'hC);
    tick();
    reset = 1'b0;
    drive(2'b00, 0, 0, 0, 0);
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL midrst_count got=%0d exp=0", count); end
    n_vec++; if (id_pc !== 64'h0) begin n_err++; $display("FAIL midrst_pc got=%h exp=0", id_pc); end
    n_vec++; if (id_instr !== 64'h0) begin n_err++; $display("FAIL midrst_instr got=%h exp=0", id_instr); end
    id_ready = 1'b1;
    tick();
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL empty_ready got=%0d exp=0", count); end
  endtask

`ifdef FETCH_QUEUE_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    id_ready = 1'b0;
    drive(2'b00, 0, 0, 0, 0);
    n_vec++; if (perf_empty_cycles !== 32'd0) begin n_err++; $display("FAIL perf_empty_rst got=%0d exp=0", perf_empty_cycles); end
    tick(); tick(); tick();
    n_vec++; if (perf_empty_cycles !== 32'd3) begin n_err++; $display("FAIL perf_empty_idle got=%0d exp=3", perf_empty_cycles); end
    drive(2'b11, 32'h600, 32'h0, 32'h604, 32'h0);
    tick();
    drive(2'b11, 32'h608, 32'h0, 32'h60C, 32'h0);
    tick();
    drive(2'b01, 32'h610, 32'h0, 32'h0, 32'h0);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    n_vec++; if (perf_stall_cycles !== 32'd0) begin n_err++; $display("FAIL perf_stall_pre got=%0d exp=0", perf_stall_cycles); end
    for (int k = 0; k < 10; k++) tick();
    n_vec++; if (perf_stall_cycles !== 32'd10) begin n_err++; $display("FAIL perf_stall got=%0d exp=10", perf_stall_cycles); end
    n_vec++; if (perf_empty_cycles !== 32'd4) begin n_err++; $display("FAIL perf_empty_hold got=%0d exp=4", perf_empty_cycles); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++; if (perf_stall_cycles !== 32'd11) begin n_err++; $display("FAIL perf_flush_keep got=%0d exp=11", perf_stall_cycles); end
  endtask
`endif

  initial begin
    reset = 1'b1; flush = 1'b0; id_ready = 1'b0;
    if_valid = '0; if_pc = '0; if_instr = '0;
    test_reset();
    test_pairs();
    test_pack();
    test_fill_stall();
    test_wrap();
    test_flush();
    test_mid_reset();
`ifdef FETCH_QUEUE_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the 2-wide fetch stage and decode. It accepts up to FETCH_W fetched instructions per cycle, packs them in program order into a circular buffer, and presents up to DEC_W of them to decode. It exerts backpressure on fetch through a stall output and discards its contents on a branch-redirect flush.

## Interface
- FETCH_W, 2, instructions per cycle accepted from fetch
- DEC_W, 2, instructions per cycle offered to decode
- PC_W, 32, PC width
- INSTR_W, 32, instruction width
- DEPTH, 8, entries; power of 2, at least 2*FETCH_W

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- if_valid  in  FETCH_W  per-slot valid from fetch; any pattern (01, 10, 11)
- if_pc  in  PC_W x FETCH_W  slot PCs
- if_instr  in  INSTR_W x FETCH_W  slot instructions
- flush  in  1  redirect flush; same signal as fetch redirect_en
- ibuf_stall  out  1  to fetch stall input
- id_ready  in  1  decode accepts all currently valid id lanes this cycle
- id_valid  out  DEC_W  thermometer-coded lane valids (lane 0 oldest)
- id_pc  out  PC_W x DEC_W  lane PCs
- id_instr  out  INSTR_W x DEC_W  lane instructions
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- State: storage[DEPTH] of {pc, instr}, head, tail (log2(DEPTH) bits, wrap modulo DEPTH), count.
- Enqueue: valid if slots are compacted in ascending slot index. Slot i writes storage[tail + rank(i)], where rank(i) is the popcount of if_valid[i-1:0]. Then tail += popcount(if_valid).
- Enqueue occurs regardless of ibuf_stall if free = DEPTH - count >= popcount(if_valid).
- If free < popcount, the whole group is dropped and a simulation assertion fires. By construction this cannot occur when fetch honours ibuf_stall.
- ibuf_stall = (free < 2*FETCH_W). This is a function of registered count only. The margin absorbs the one in-flight group caused by the 1-cycle imem latency.
- Dequeue: id_valid[i] = (count > i). Lane i shows storage[head + i].
- If id_ready is high, deq = min(count, DEC_W), head += deq. If id_ready is low, nothing is consumed.
- Next count = count + enq - deq. The free check uses pre-dequeue count (conservative).
- Flush has priority over everything: head = tail = count = 0, and the same-cycle enqueue and dequeue are ignored. Storage contents are not required to be cleared.
- Reset: head, tail and count are 0 and storage is zeroed. Outputs: id_valid = 0, id_pc = id_instr = 0, ibuf_stall = 0, count = 0.
- Inputs arriving while reset is high are discarded. Reset mid-operation behaves identically to flush plus storage clear.

## Timing
- Latency: an instruction enqueued at edge N is visible on id_* after edge N (1 cycle from if_valid to id_valid).
- id_* outputs and ibuf_stall are combinational from registers only. There is no input-to-output path.
- With sustained 2-in/2-out, count stays constant and throughput is 2 instructions per cycle.
- Full: count = DEPTH, ibuf_stall = 1, and any nonzero enqueue triggers the overflow assertion.
- Empty: id_valid = 0, and id_ready has no effect.
- Simultaneous enqueue and dequeue when count = DEPTH-1 with 2 valid slots is not accepted; the group is dropped with the assertion, since the free check is pre-dequeue.
- Pointer wrap: tail or head passing DEPTH-1 continues at 0 with no gap. A 2-wide write straddling the wrap splits across entries DEPTH-1 and 0.

## Configuration
- FETCH_QUEUE_PERF_EN
  - Defined: adds outputs perf_stall_cycles[31:0] (cycles with ibuf_stall = 1) and perf_empty_cycles[31:0] (cycles with count = 0, reset low).
  - Both counters saturate at all-ones, are cleared by reset, and are not cleared by flush.
  - Undefined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then pairs {0x11111111@0x00, 0x22222222@0x04} and {0x33333333@0x08, 0x44444444@0x0C} with id_ready=1 -> id_valid=11 one cycle after each pair, in order, and count returns to 0.
- if_valid=10 with {x, 0x66666666@0x14} -> entry packed into lane 0: id_valid=01, id_pc[0]=0x14.
- id_ready=0, fill with 2-wide groups -> ibuf_stall rises when count reaches 5 (DEPTH 8); count never exceeds 8; no assertion.
- Fill to 6, then drain 2 per cycle while enqueuing 2 per cycle across the wrap -> PCs emerge strictly sequential through the head/tail wrap at 7->0.
- count=5 and flush with if_valid=11 in the same cycle -> next cycle count=0, id_valid=00, ibuf_stall=0; the following pair at 0x08/0x0C appears in lanes 0/1.
- With FETCH_QUEUE_PERF_EN: hold id_ready=0 for 10 cycles after fill -> perf_stall_cycles increments once per stalled cycle. perf_empty_cycles counts idle cycles after reset.
